aes_256_sched: RTL and testbench

AES_256_SCHED -- requirements
Module: aes_256_sched

---
 rtl/aes_256_sched.sv | 140 ++++++++++++++
 tb/tb_aes_256_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_256_sched.sv
// aes_256_sched: arbitrates two AES-256 requesters onto one fixed-latency external core and
// returns ciphertexts in acceptance order through a credit-protected response FIFO.
// Optional macro AES_SCHED_RR_EN selects round-robin arbitration (default: fixed priority REQ0 > REQ1).
module aes_256_sched #(
    parameter int CORE_LAT   = 30,
    parameter int FIFO_DEPTH = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0_VALID,
    output logic         REQ0_READY,
    input  logic [127:0] REQ0_STATE,
    input  logic [255:0] REQ0_KEY,
    input  logic         REQ1_VALID,
    output logic         REQ1_READY,
    input  logic [127:0] REQ1_STATE,
    input  logic [255:0] REQ1_KEY,
    output logic [127:0] CORE_STATE,
    output logic [255:0] CORE_KEY,
    input  logic [127:0] CORE_OUT,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic [127:0] RSP_DATA,
    output logic         RSP_ID,
    output logic [6:0]   INFLIGHT
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                ready_en_q, ready_en_d;
    logic [6:0]          inflight_q, inflight_d;
    logic [CORE_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [CORE_LAT-1:0] tag_id_q, tag_id_d;
    logic [127:0]        core_state_q, core_state_d;
    logic [255:0]        core_key_q, core_key_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [128:0]        fifo_mem_q [FIFO_DEPTH];
    logic                credit;
    logic                grant1;
    logic                hs;
    logic                wr;
    logic                rd;

`ifdef AES_SCHED_RR_EN
    logic last_q, last_d;

    // last_q=1 means REQ1 was granted last, so REQ0 wins the next contested cycle
    always_comb begin
        grant1 = REQ1_VALID & (~REQ0_VALID | ~last_q);
    end

    always_comb begin
        last_d = last_q;
        if (hs) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant1 = REQ1_VALID & ~REQ0_VALID;
    end
`endif

    // Credit covers both the core pipeline and the FIFO, so a write always finds space
    always_comb begin
        credit     = inflight_q < 7'(FIFO_DEPTH);
        REQ0_READY = ready_en_q & ~RST & credit & REQ0_VALID & ~grant1;
        REQ1_READY = ready_en_q & ~RST & credit & grant1;
        hs         = REQ0_READY | REQ1_READY;
    end

    always_comb begin
        wr        = tag_vld_q[CORE_LAT-1];
        RSP_VALID = (count_q != '0) & ~RST;
        rd        = RSP_VALID & RSP_READY;
        RSP_DATA  = fifo_mem_q[rd_ptr_q][127:0];
        RSP_ID    = fifo_mem_q[rd_ptr_q][128];
    end

    always_comb begin
        ready_en_d   = 1'b1;
        inflight_d   = inflight_q + 7'(hs) - 7'(rd);
        tag_vld_d    = (tag_vld_q << 1) | CORE_LAT'(hs);
        tag_id_d     = (tag_id_q << 1) | CORE_LAT'(grant1);
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (hs) begin
            core_state_d = grant1 ? REQ1_STATE : REQ0_STATE;
            core_key_d   = grant1 ? REQ1_KEY : REQ0_KEY;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd);
        count_d  = count_q + CNT_W'(wr) - CNT_W'(rd);
    end

    // Clearing tag valids on reset is what keeps stale CORE_OUT values out of the FIFO
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_en_q   <= 1'b0;
            inflight_q   <= '0;
            tag_vld_q    <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            ready_en_q   <= ready_en_d;
            inflight_q   <= inflight_d;
            tag_vld_q    <= tag_vld_d;
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_id_q <= tag_id_d;
        if (wr) begin
            fifo_mem_q[wr_ptr_q] <= {tag_id_q[CORE_LAT-1], CORE_OUT};
        end
    end

    assign CORE_STATE = core_state_q;
    assign CORE_KEY   = core_key_q;
    assign INFLIGHT   = inflight_q;

endmodule

// File: tb/tb_aes_256_sched.sv
// Directed bench for aes_256_sched with a behavioural AES-256 core of CORE_LAT cycles.
module tb_aes_256_sched;
    localparam int CORE_LAT   = 30;
    localparam int FIFO_DEPTH = 32;
    localparam logic [255:0] K0 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K1 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_state = '0, req1_state = '0;
    logic [255:0] req0_key = '0, req1_key = '0;
    logic [127:0] core_state;
    logic [255:0] core_key;
    logic [127:0] core_out;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic [6:0]   inflight;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int both_rdy = 0;

    typedef struct {
        logic [127:0] data;
        logic         id;
        int           cyc;
    } ent_t;
    ent_t acc_q[$];
    ent_t rsp_q[$];

    aes_256_sched #(.CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_STATE(req0_state), .REQ0_KEY(req0_key),
        .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_STATE(req1_state), .REQ1_KEY(req1_key),
        .CORE_STATE(core_state), .CORE_KEY(core_key), .CORE_OUT(core_out),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ID(rsp_id),
        .INFLIGHT(inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                      {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 14) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    function automatic logic [127:0] pay(input logic [31:0] tagv, input int n);
        return {tagv, 64'h0123_4567_89ab_cdef, 32'(n)};
    endfunction

    // Core model: result of operands seen after edge t is on core_out by edge t+CORE_LAT
    logic [127:0] core_pipe [CORE_LAT];
    logic [127:0] last_st, last_ct;
    logic [255:0] last_key;
    bit           cache_ok = 1'b0;
    assign core_out = core_pipe[CORE_LAT-1];

    always @(negedge clk) begin
        if (!cache_ok || core_state !== last_st || core_key !== last_key) begin
            last_st  = core_state;
            last_key = core_key;
            last_ct  = aes256(core_state, core_key);
            cache_ok = 1'b1;
        end
        for (int i = CORE_LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= last_ct;
    end

    always @(negedge clk) begin
        ent_t e;
        if (req0_ready && req1_ready) both_rdy++;
        if (req0_valid && req0_ready) begin
            e.data = aes256(req0_state, req0_key); e.id = 1'b0; e.cyc = cyc; acc_q.push_back(e);
        end
        if (req1_valid && req1_ready) begin
            e.data = aes256(req1_state, req1_key); e.id = 1'b1; e.cyc = cyc; acc_q.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
            e.data = rsp_data; e.id = rsp_id; e.cyc = cyc; rsp_q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b expected 0", req0_ready); else passed++;
        checks++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b expected 0", req1_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        checks++; if (inflight !== 7'd0) $display("FAIL rst_inflight: got %0d expected 0", inflight); else passed++;
        checks++; if (core_state !== 128'h0) $display("FAIL rst_core_state: got %h expected 0", core_state); else passed++;
        checks++; if (core_key !== 256'h0) $display("FAIL rst_core_key: got %h expected 0", core_key); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0) $display("FAIL post_rst_ready0: got %b expected 0", req0_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL post_rst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        acc_q.delete(); rsp_q.delete(); both_rdy = 0;
    endtask

    task automatic test_single();
        logic [255:0] key;
        logic [127:0] st;
        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        st  = 128'h00112233445566778899aabbccddeeff;
        req0_state = st; req0_key = key; req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", req0_ready); else passed++;
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (core_state !== st) $display("FAIL single_core_state: got %h expected %h", core_state, st); else passed++;
        checks++; if (core_key !== key) $display("FAIL single_core_key: got %h expected %h", core_key, key); else passed++;
        checks++; if (inflight !== 7'd1) $display("FAIL single_inflight: got %0d expected 1", inflight); else passed++;
        for (int i = 0; i < CORE_LAT + 20 && rsp_q.size() == 0; i++) tick();
        checks++; if (rsp_q.size() != 1 || acc_q.size() != 1)
            $display("FAIL single_count: got rsp %0d acc %0d expected 1 1", rsp_q.size(), acc_q.size()); else passed++;
        if (rsp_q.size() > 0 && acc_q.size() > 0) begin
            checks++; if (rsp_q[0].data !== 128'h8ea2b7ca516745bfeafc49904b496089)
                $display("FAIL single_data: got %h expected 8ea2b7ca516745bfeafc49904b496089", rsp_q[0].data); else passed++;
            checks++; if (rsp_q[0].id !== 1'b0) $display("FAIL single_id: got %b expected 0", rsp_q[0].id); else passed++;
            checks++; if (rsp_q[0].cyc - acc_q[0].cyc != CORE_LAT + 1)
                $display("FAIL single_latency: got %0d expected %0d", rsp_q[0].cyc - acc_q[0].cyc, CORE_LAT + 1); else passed++;
        end
        tick();
        checks++; if (inflight !== 7'd0) $display("FAIL single_inflight_end: got %0d expected 0", inflight); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_empty: got %b expected 0", rsp_valid); else passed++;
        acc_q.delete(); rsp_q.delete();
    endtask

    task automatic test_arbitration();
        int n0, n1;
        logic h0, h1, exp_id;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        acc_q.delete(); rsp_q.delete(); both_rdy = 0;
        n0 = 0; n1 = 0;
        req0_key = K0; req1_key = K1; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_state = pay(32'hA0A0_0000, n0); req1_state = pay(32'hA1A1_0000, n1);
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1 h0 = req0_ready; h1 = req1_ready;
            tick();
            if (h0) n0++;
            if (h1) n1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (acc_q.size() != 8) $display("FAIL arb_grants: got %0d expected 8", acc_q.size()); else passed++;
        checks++; if (both_rdy != 0) $display("FAIL arb_both_ready: got %0d cycles expected 0", both_rdy); else passed++;
        for (int i = 0; i < acc_q.size(); i++) begin
`ifdef AES_SCHED_RR_EN
            exp_id = 1'(i % 2);
`else
            exp_id = 1'b0;
`endif
            checks++; if (acc_q[i].id !== exp_id) $display("FAIL arb_grant_%0d: got %b expected %b", i, acc_q[i].id, exp_id); else passed++;
        end
        for (int i = 0; i < CORE_LAT + 40 && rsp_q.size() < acc_q.size(); i++) tick();
        checks++; if (rsp_q.size() != acc_q.size())
            $display("FAIL arb_rsp_count: got %0d expected %0d", rsp_q.size(), acc_q.size()); else passed++;
        for (int i = 0; i < rsp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (rsp_q[i].data !== acc_q[i].data || rsp_q[i].id !== acc_q[i].id)
                $display("FAIL arb_rsp_%0d: got %h/%b expected %h/%b", i, rsp_q[i].data, rsp_q[i].id, acc_q[i].data, acc_q[i].id); else passed++;
        end
        acc_q.delete(); rsp_q.delete();
    endtask

    task automatic test_credit();
        int n;
        logic h0;
        n = 0; rsp_ready = 1'b0; req0_key = K0;
        for (int c = 0; c < 40; c++) begin
            req0_state = pay(32'hC0C0_0000, n); req0_valid = 1'b1;
            #1 h0 = req0_ready;
            tick();
            if (h0) n++;
        end
        #1;
        checks++; if (acc_q.size() != FIFO_DEPTH) $display("FAIL credit_accepted: got %0d expected %0d", acc_q.size(), FIFO_DEPTH); else passed++;
        checks++; if (req0_ready !== 1'b0) $display("FAIL credit_ready_low: got %b expected 0", req0_ready); else passed++;
        checks++; if (inflight !== 7'(FIFO_DEPTH)) $display("FAIL credit_inflight: got %0d expected %0d", inflight, FIFO_DEPTH); else passed++;
        repeat (40) tick();
        checks++; if (acc_q.size() != FIFO_DEPTH) $display("FAIL credit_hold: got %0d expected %0d", acc_q.size(), FIFO_DEPTH); else passed++;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL credit_rsp_valid: got %b expected 1", rsp_valid); else passed++;
        if (acc_q.size() > 0) begin
            checks++; if (rsp_data !== acc_q[0].data || rsp_id !== 1'b0)
                $display("FAIL credit_stall_head: got %h/%b expected %h/0", rsp_data, rsp_id, acc_q[0].data); else passed++;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0) $display("FAIL credit_ready_vs_rsp_ready: got %b expected 0", req0_ready); else passed++;
        tick();
        #1;
        checks++; if (req0_ready !== 1'b1) $display("FAIL credit_resume: got %b expected 1", req0_ready); else passed++;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < CORE_LAT + 80 && rsp_q.size() < FIFO_DEPTH + 1; i++) tick();
        checks++; if (acc_q.size() != FIFO_DEPTH + 1 || rsp_q.size() != FIFO_DEPTH + 1)
            $display("FAIL credit_total: got acc %0d rsp %0d expected %0d", acc_q.size(), rsp_q.size(), FIFO_DEPTH + 1); else passed++;
        if (acc_q.size() > FIFO_DEPTH && rsp_q.size() > 0) begin
            checks++; if (acc_q[FIFO_DEPTH].cyc != rsp_q[0].cyc + 1)
                $display("FAIL credit_resume_cycle: got %0d expected %0d", acc_q[FIFO_DEPTH].cyc, rsp_q[0].cyc + 1); else passed++;
        end
        for (int i = 0; i < rsp_q.size() && i < acc_q.size(); i++) begin
            checks++; if (rsp_q[i].data !== aes256(pay(32'hC0C0_0000, i), K0) || rsp_q[i].id !== 1'b0)
                $display("FAIL credit_rsp_%0d: got %h/%b expected %h/0", i, rsp_q[i].data, rsp_q[i].id, aes256(pay(32'hC0C0_0000, i), K0)); else passed++;
        end
        checks++; if (inflight !== 7'd0) $display("FAIL credit_inflight_end: got %0d expected 0", inflight); else passed++;
        acc_q.delete(); rsp_q.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        logic hs, sel, exp_id;
        logic [127:0] exp_d;
        n = 0; rsp_ready = 1'b1; both_rdy = 0;
        req0_key = K0; req1_key = K1;
        for (int c = 0; c < 300 && n < 100; c++) begin
            sel = (n % 3 == 2);
            req0_state = pay(32'hB0B0_0000, n); req1_state = pay(32'hB1B1_0000, n);
            req0_valid = !sel; req1_valid = sel;
            #1 hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);
            tick();
            if (hs) n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (acc_q.size() != 100) $display("FAIL b2b_accepted: got %0d expected 100", acc_q.size()); else passed++;
        if (acc_q.size() == 100) begin
            checks++; if (acc_q[99].cyc - acc_q[0].cyc != 99)
                $display("FAIL b2b_span: got %0d expected 99", acc_q[99].cyc - acc_q[0].cyc); else passed++;
        end
        for (int i = 0; i < CORE_LAT + 200 && rsp_q.size() < 100; i++) tick();
        checks++; if (rsp_q.size() != 100) $display("FAIL b2b_rsp_count: got %0d expected 100", rsp_q.size()); else passed++;
        for (int i = 0; i < rsp_q.size(); i++) begin
            exp_id = (i % 3 == 2);
            exp_d  = exp_id ? aes256(pay(32'hB1B1_0000, i), K1) : aes256(pay(32'hB0B0_0000, i), K0);
            checks++; if (rsp_q[i].data !== exp_d || rsp_q[i].id !== exp_id)
                $display("FAIL b2b_rsp_%0d: got %h/%b expected %h/%b", i, rsp_q[i].data, rsp_q[i].id, exp_d, exp_id); else passed++;
        end
        checks++; if (both_rdy != 0) $display("FAIL b2b_both_ready: got %0d expected 0", both_rdy); else passed++;
        acc_q.delete(); rsp_q.delete();
    endtask

    task automatic test_reset_mid();
        int bad;
        logic [127:0] exp_d;
        rsp_ready = 1'b0; req0_key = K0;
        for (int c = 0; c < 15; c++) begin
            req0_state = pay(32'hD0D0_0000, c); req0_valid = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        repeat (CORE_LAT - 10) tick();
        checks++; if (inflight !== 7'd15) $display("FAIL rmid_inflight_before: got %0d expected 15", inflight); else passed++;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL rmid_buffered: got %b expected 1", rsp_valid); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_rsp_in_rst: got %b expected 0", rsp_valid); else passed++;
        tick();
        rst = 1'b0; rsp_ready = 1'b1;
        checks++; if (inflight !== 7'd0) $display("FAIL rmid_inflight_after: got %0d expected 0", inflight); else passed++;
        checks++; if (core_state !== 128'h0) $display("FAIL rmid_core_state: got %h expected 0", core_state); else passed++;
        bad = 0;
        for (int i = 0; i < CORE_LAT + 2; i++) begin
            #1 if (rsp_valid !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) $display("FAIL rmid_stale_rsp: got %0d valid cycles expected 0", bad); else passed++;
        checks++; if (rsp_q.size() != 0) $display("FAIL rmid_stale_pop: got %0d expected 0", rsp_q.size()); else passed++;
        acc_q.delete(); rsp_q.delete();
        req1_key = K1; req1_state = pay(32'hE1E1_0000, 7); req1_valid = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1) $display("FAIL rmid_ready1: got %b expected 1", req1_ready); else passed++;
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < CORE_LAT + 20 && rsp_q.size() == 0; i++) tick();
        repeat (3) tick();
        exp_d = aes256(pay(32'hE1E1_0000, 7), K1);
        checks++; if (rsp_q.size() != 1) $display("FAIL rmid_next_count: got %0d expected 1", rsp_q.size()); else passed++;
        if (rsp_q.size() > 0 && acc_q.size() > 0) begin
            checks++; if (rsp_q[0].data !== exp_d || rsp_q[0].id !== 1'b1)
                $display("FAIL rmid_next_rsp: got %h/%b expected %h/1", rsp_q[0].data, rsp_q[0].id, exp_d); else passed++;
            checks++; if (rsp_q[0].cyc - acc_q[0].cyc != CORE_LAT + 1)
                $display("FAIL rmid_next_latency: got %0d expected %0d", rsp_q[0].cyc - acc_q[0].cyc, CORE_LAT + 1); else passed++;
        end
        acc_q.delete(); rsp_q.delete();
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_single();
        test_arbitration();
        test_credit();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
